// File: rtl/rr_fifo_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rr_fifo_arbiter                                              |
// | Brief   : Round-robin drain of four class FIFOs into one downstream    |
// |           FIFO through a 2-entry skid buffer.                          |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rr_fifo_arbiter #(
    parameter int DATA_SIZE = 6,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data0,
    input  logic [DATA_SIZE-1:0] fifo_data1,
    input  logic [DATA_SIZE-1:0] fifo_data2,
    input  logic [DATA_SIZE-1:0] fifo_data3,
    output logic [3:0]           fifo_read,
    input  logic                 down_full,
    input  logic                 down_pause,
    output logic                 down_write,
    output logic [DATA_SIZE-1:0] down_data,
    output logic [1:0]           down_src,
    output logic [1:0]           arb_state,
    output logic [CNT_SIZE-1:0]  words_sent,
    output logic                 arb_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] c_LAST_RST = 2'd3;

    state_t               r_state_q,    w_state_d;
    logic [1:0]           r_last_q,     w_last_d;
    logic                 r_inflight_q, w_inflight_d;
    logic [1:0]           r_idx_q,      w_idx_d;
    logic [1:0]           r_cnt_q,      w_cnt_d;
    logic [DATA_SIZE-1:0] r_data0_q,    w_data0_d;
    logic [DATA_SIZE-1:0] r_data1_q,    w_data1_d;
    logic [1:0]           r_src0_q,     w_src0_d;
    logic [1:0]           r_src1_q,     w_src1_d;
    logic [CNT_SIZE-1:0]  r_sent_q,     w_sent_d;
    logic                 r_err_q,      w_err_d;

    logic                 w_any;
    logic                 w_found;
    logic [1:0]           w_cand;
    logic [1:0]           w_grant;
    logic [2:0]           w_occ;
    logic                 w_issue;
    logic [DATA_SIZE-1:0] w_cap_data;

    assign w_any = |(~fifo_empty);

    // Search last+1 .. last+4 (mod 4) for the first non-empty source.
    always_comb begin
        w_grant = r_last_q;
        w_found = 1'b0;
        w_cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last_q + k[1:0];
            if (!w_found && !fifo_empty[w_cand]) begin
                w_grant = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // Occupancy counts the inflight word so the skid can never overflow.
    assign w_occ      = {1'b0, r_cnt_q} + {2'b00, r_inflight_q};
    assign down_write = (r_cnt_q != 2'd0) && !down_full;
    assign w_issue    = !reset && w_any && !down_pause && !down_full &&
                        ((w_occ - {2'b00, down_write}) < 3'd2);
    assign fifo_read  = w_issue ? (4'b0001 << w_grant) : 4'b0000;

    assign down_data  = r_data0_q;
    assign down_src   = r_src0_q;
    assign arb_state  = r_state_q;
    assign words_sent = r_sent_q;
    assign arb_error  = r_err_q;

    always_comb begin
        case (r_idx_q)
            2'd0:    w_cap_data = fifo_data0;
            2'd1:    w_cap_data = fifo_data1;
            2'd2:    w_cap_data = fifo_data2;
            default: w_cap_data = fifo_data3;
        endcase
    end

    always_comb begin
        w_last_d     = w_issue ? w_grant : r_last_q;
        w_inflight_d = w_issue;
        w_idx_d      = w_issue ? w_grant : r_idx_q;
        w_sent_d     = r_sent_q + {{(CNT_SIZE-1){1'b0}}, down_write};
    end

    // Skid buffer: entry 0 is the head; capture and drain may coincide.
    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_data0_d = r_data0_q;
        w_data1_d = r_data1_q;
        w_src0_d  = r_src0_q;
        w_src1_d  = r_src1_q;
        w_err_d   = r_err_q;
        case ({r_inflight_q, down_write})
            2'b01: begin
                w_data0_d = r_data1_q;
                w_src0_d  = r_src1_q;
                w_cnt_d   = r_cnt_q - 2'd1;
            end
            2'b10: begin
                if (r_cnt_q == 2'd0) begin
                    w_data0_d = w_cap_data;
                    w_src0_d  = r_idx_q;
                    w_cnt_d   = 2'd1;
                end else if (r_cnt_q == 2'd1) begin
                    w_data1_d = w_cap_data;
                    w_src1_d  = r_idx_q;
                    w_cnt_d   = 2'd2;
                end else begin
                    w_err_d   = 1'b1;
                end
            end
            2'b11: begin
                if (r_cnt_q == 2'd1) begin
                    w_data0_d = w_cap_data;
                    w_src0_d  = r_idx_q;
                end else begin
                    w_data0_d = r_data1_q;
                    w_src0_d  = r_src1_q;
                    w_data1_d = w_cap_data;
                    w_src1_d  = r_idx_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d = ST_IDLE;
        if (down_pause || down_full) begin
            w_state_d = ST_PAUSE;
        end else if (w_any || (r_cnt_q != 2'd0) || r_inflight_q) begin
            w_state_d = ST_ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_last_q     <= c_LAST_RST;
            r_inflight_q <= 1'b0;
            r_idx_q      <= 2'd0;
            r_cnt_q      <= 2'd0;
            r_data0_q    <= '0;
            r_data1_q    <= '0;
            r_src0_q     <= 2'd0;
            r_src1_q     <= 2'd0;
            r_sent_q     <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_last_q     <= w_last_d;
            r_inflight_q <= w_inflight_d;
            r_idx_q      <= w_idx_d;
            r_cnt_q      <= w_cnt_d;
            r_data0_q    <= w_data0_d;
            r_data1_q    <= w_data1_d;
            r_src0_q     <= w_src0_d;
            r_src1_q     <= w_src1_d;
            r_sent_q     <= w_sent_d;
            r_err_q      <= w_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_fifo_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_rr_fifo_arbiter                                           |
// | Brief   : Randomized bench for rr_fifo_arbiter with a queue-based      |
// |           model of the upstream FIFOs and the delivered word stream.   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_rr_fifo_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] fifo_empty = 4'hF;
    logic [5:0] fd [4];
    logic [3:0] fifo_read;
    logic       down_full = 1'b0;
    logic       down_pause = 1'b0;
    logic       down_write;
    logic [5:0] down_data;
    logic [1:0] down_src;
    logic [1:0] arb_state;
    logic [7:0] words_sent;
    logic       arb_error;

    rr_fifo_arbiter #(.DATA_SIZE(6), .CNT_SIZE(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data0 (fd[0]),
        .fifo_data1 (fd[1]),
        .fifo_data2 (fd[2]),
        .fifo_data3 (fd[3]),
        .fifo_read  (fifo_read),
        .down_full  (down_full),
        .down_pause (down_pause),
        .down_write (down_write),
        .down_data  (down_data),
        .down_src   (down_src),
        .arb_state  (arb_state),
        .words_sent (words_sent),
        .arb_error  (arb_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: upstream contents, words popped but not yet delivered, pointer.
    logic [5:0] uq [4][$];
    logic [7:0] sb [$];
    int         m_inflight = 0;
    logic [1:0] m_last = 2'd3;
    logic [7:0] m_sent = 8'd0;

    logic [3:0] e_read, o_read;
    logic       e_write, o_write, e_issue;
    logic [5:0] e_data, o_data;
    logic [1:0] e_src, o_src, e_state, o_state;
    logic [7:0] o_sent;
    logic       o_err;

    task automatic refresh_empty();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (uq[i].size() == 0);
    endtask

    task automatic step();
        int  g;
        int  c;
        int  skid;
        bit  any;
        logic [5:0] w;
        refresh_empty();
        @(negedge clk);
        any = 0;
        g   = 0;
        for (int k = 1; k <= 4; k++) begin
            c = (int'(m_last) + k) % 4;
            if (!any && uq[c].size() > 0) begin
                any = 1;
                g   = c;
            end
        end
        skid    = sb.size() - m_inflight;
        e_write = (skid > 0) && !down_full;
        e_issue = !reset && any && !down_pause && !down_full &&
                  ((sb.size() - int'(e_write)) < 2);
        e_read  = e_issue ? (4'b0001 << g) : 4'b0000;
        e_data  = (sb.size() > 0) ? sb[0][5:0] : 6'd0;
        e_src   = (sb.size() > 0) ? sb[0][7:6] : 2'd0;
        if (reset)                             e_state = 2'd0;
        else if (down_pause || down_full)      e_state = 2'd2;
        else if (any || skid > 0 || m_inflight != 0) e_state = 2'd1;
        else                                   e_state = 2'd0;
        o_read  = fifo_read;
        o_write = down_write;
        o_data  = down_data;
        o_src   = down_src;
        @(posedge clk);
        #1;
        if (reset) begin
            sb.delete();
            m_inflight = 0;
            m_last     = 2'd3;
            m_sent     = 8'd0;
        end else begin
            if (e_write && sb.size() > 0) begin
                void'(sb.pop_front());
                m_sent = m_sent + 8'd1;
            end
            if (e_issue) begin
                w     = uq[g].pop_front();
                fd[g] = w;
                sb.push_back({2'(g), w});
                m_last = 2'(g);
            end
            m_inflight = e_issue ? 1 : 0;
        end
        refresh_empty();
        o_state = arb_state;
        o_sent  = words_sent;
        o_err   = arb_error;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL reset_read got=%b exp=0000", fifo_read); end
        total++; if (down_write !== 1'b0)   begin bad++; $display("FAIL reset_write got=%b exp=0", down_write); end
        total++; if (down_data !== 6'd0 || down_src !== 2'd0) begin bad++; $display("FAIL reset_data got=%h/%0d exp=0/0", down_data, down_src); end
        total++; if (arb_state !== 2'd0)    begin bad++; $display("FAIL reset_state got=%0d exp=0", arb_state); end
        total++; if (words_sent !== 8'd0 || arb_error !== 1'b0) begin bad++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", words_sent, arb_error); end
        reset = 1'b0;
    endtask

    task automatic test_single_source();
        int nw;
        do_reset();
        uq[0].push_back(6'h11); uq[0].push_back(6'h12); uq[0].push_back(6'h13);
        nw = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            total++; if (o_read !== ((i < 3) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_read cyc=%0d got=%b exp=%b", i, o_read, (i < 3) ? 4'b0001 : 4'b0000); end
            total++; if (o_write !== (i >= 2 && i <= 4)) begin bad++; $display("FAIL single_write cyc=%0d got=%b exp=%b", i, o_write, (i >= 2 && i <= 4)); end
            if (o_write) begin
                total++; if (o_data !== 6'h11 + 6'(nw) || o_src !== 2'd0) begin bad++; $display("FAIL single_data got=%h/%0d exp=%h/0", o_data, o_src, 6'h11 + 6'(nw)); end
                nw++;
            end
        end
        total++; if (words_sent !== 8'd3) begin bad++; $display("FAIL single_sent got=%0d exp=3", words_sent); end
    endtask

    task automatic test_all_four();
        int ng;
        int nw;
        do_reset();
        for (int i = 0; i < 4; i++) uq[i].push_back(6'(i + 1));
        ng = 0;
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_read != 4'b0000) begin
                total++; if (o_read !== (4'b0001 << ng)) begin bad++; $display("FAIL four_grant n=%0d got=%b exp=%b", ng, o_read, 4'b0001 << ng); end
                ng++;
            end
            if (o_write) begin
                total++; if (o_data !== 6'(nw + 1) || o_src !== 2'(nw)) begin bad++; $display("FAIL four_data n=%0d got=%h/%0d exp=%h/%0d", nw, o_data, o_src, nw + 1, nw); end
                nw++;
            end
        end
        total++; if (ng != 4 || nw != 4) begin bad++; $display("FAIL four_count got=%0d/%0d exp=4/4", ng, nw); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 10; i++) uq[2].push_back(6'($urandom_range(0, 63)));
        for (int i = 0; i < 24; i++) begin
            down_full = (i >= 3 && i < 7);
            step();
            total++; if (o_read !== e_read || o_write !== e_write) begin bad++; $display("FAIL full_ctl cyc=%0d got=%b/%b exp=%b/%b", i, o_read, o_write, e_read, e_write); end
            if (down_full) begin
                total++; if (o_read !== 4'b0000 || o_write !== 1'b0) begin bad++; $display("FAIL full_block cyc=%0d got=%b/%b exp=0000/0", i, o_read, o_write); end
            end
            if (e_write) begin
                total++; if (o_data !== e_data || o_src !== e_src) begin bad++; $display("FAIL full_data cyc=%0d got=%h/%0d exp=%h/%0d", i, o_data, o_src, e_data, e_src); end
            end
        end
        down_full = 1'b0;
        total++; if (o_err !== 1'b0 || o_sent !== m_sent) begin bad++; $display("FAIL full_end got=%b/%0d exp=0/%0d", o_err, o_sent, m_sent); end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) uq[i].push_back(6'($urandom_range(0, 63)));
        for (int i = 0; i < 24; i++) begin
            down_pause = (i >= 2 && i < 6);
            step();
            if (down_pause) begin
                total++; if (o_read !== 4'b0000 || o_state !== 2'd2) begin bad++; $display("FAIL pause_hold cyc=%0d got=%b/%0d exp=0000/2", i, o_read, o_state); end
            end
            total++; if (o_read !== e_read || o_write !== e_write) begin bad++; $display("FAIL pause_ctl cyc=%0d got=%b/%b exp=%b/%b", i, o_read, o_write, e_read, e_write); end
            if (e_write) begin
                total++; if (o_data !== e_data || o_src !== e_src) begin bad++; $display("FAIL pause_data cyc=%0d got=%h/%0d exp=%h/%0d", i, o_data, o_src, e_data, e_src); end
            end
        end
        down_pause = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int low;
        for (int i = 1; i < 4; i++)
            for (int j = 0; j < 4; j++) uq[i].push_back(6'($urandom_range(0, 63)));
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (o_read !== 4'b0000) begin bad++; $display("FAIL midreset_read got=%b exp=0000", o_read); end
        total++; if (down_write !== 1'b0 || down_data !== 6'd0 || down_src !== 2'd0) begin bad++; $display("FAIL midreset_out got=%b/%h/%0d exp=0/0/0", down_write, down_data, down_src); end
        total++; if (arb_state !== 2'd0 || words_sent !== 8'd0 || arb_error !== 1'b0) begin bad++; $display("FAIL midreset_stat got=%0d/%0d/%b exp=0/0/0", arb_state, words_sent, arb_error); end
        low = -1;
        for (int i = 3; i >= 0; i--) if (uq[i].size() > 0) low = i;
        step();
        total++; if (low < 0 || o_read !== (4'b0001 << low)) begin bad++; $display("FAIL midreset_grant got=%b exp_idx=%0d", o_read, low); end
        for (int i = 0; i < 20; i++) step();
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = $urandom_range(0, 3);
                if (uq[c].size() < 6) uq[c].push_back(6'($urandom_range(0, 63)));
            end
            down_full  = ($urandom_range(0, 4) == 0);
            down_pause = ($urandom_range(0, 5) == 0);
            step();
            total++; if (o_read !== e_read) begin bad++; $display("FAIL rand_read cyc=%0d got=%b exp=%b", i, o_read, e_read); end
            total++; if (o_write !== e_write) begin bad++; $display("FAIL rand_write cyc=%0d got=%b exp=%b", i, o_write, e_write); end
            if (e_write) begin
                total++; if (o_data !== e_data || o_src !== e_src) begin bad++; $display("FAIL rand_data cyc=%0d got=%h/%0d exp=%h/%0d", i, o_data, o_src, e_data, e_src); end
            end
            total++; if (o_state !== e_state) begin bad++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", i, o_state, e_state); end
            total++; if (o_sent !== m_sent || o_err !== 1'b0) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d/%b exp=%0d/0", i, o_sent, o_err, m_sent); end
        end
        down_full  = 1'b0;
        down_pause = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        for (int i = 0; i < 260; i++) uq[1].push_back(6'(i));
        cyc = 0;
        while ((uq[1].size() > 0 || sb.size() > 0) && cyc < 400) begin
            step();
            if (e_write) begin
                total++; if (o_write !== 1'b1 || o_data !== e_data) begin bad++; $display("FAIL wrap_data cyc=%0d got=%b/%h exp=1/%h", cyc, o_write, o_data, e_data); end
            end
            cyc++;
        end
        total++; if (cyc >= 400) begin bad++; $display("FAIL wrap_timeout cycles=%0d limit=400", cyc); end
        total++; if (words_sent !== 8'd4) begin bad++; $display("FAIL wrap_sent got=%0d exp=4", words_sent); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) fd[i] = 6'd0;
        test_reset();
        test_single_source();
        test_all_four();
        test_full();
        test_pause();
        test_reset_midstream();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
